// File: rtl/microbot_pkg.sv
// Shared types for the microbot motor path: direction encoding, H-bridge
// leg patterns and the direction sequencer state encoding.
package microbot_pkg;

    // Direction command encoding as issued by the navigation FSM.
    typedef enum logic [1:0] {
        STANDBY = 2'd0,
        FORWARD = 2'd1,
        RIGHT   = 2'd2,
        LEFT    = 2'd3
    } dir_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        STBY = 2'd0,
        DEAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } seq_state_t;

    // Bridge leg patterns, bit order {A_d, A_i, B_d, B_i}.
    localparam logic [3:0] PAT_STANDBY = 4'b0000;
    localparam logic [3:0] PAT_FORWARD = 4'b1010;
    localparam logic [3:0] PAT_RIGHT   = 4'b1001;
    localparam logic [3:0] PAT_LEFT    = 4'b0110;

    // Leg pattern for a direction.
    function automatic logic [3:0] dir_pattern(input dir_t d);
        logic [3:0] p;
        case (d)
            FORWARD: p = PAT_FORWARD;
            RIGHT:   p = PAT_RIGHT;
            LEFT:    p = PAT_LEFT;
            default: p = PAT_STANDBY;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM counter and gate for bridge speed control.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   duty       - duty cycle; 0 = never on, all-ones = always on
//   gate       - combinational enable for the active bridge legs
module motor_pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                gate
);

    logic [PWM_BITS-1:0] pc;

    // Counter wraps naturally at 2^PWM_BITS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc + PWM_BITS'(1);
        end
    end

    // All-ones duty forces the gate on so full speed has no off slot.
    assign gate = (pc < duty) | (&duty);

endmodule

// File: rtl/motor_dir_sequencer.sv
// Direction sequencer between the navigation FSM and the H-bridge pins.
// Accepts direction commands on a valid/ready handshake, inserts an all-off
// dead time between different running directions, holds each new direction
// for a minimum time and PWM-gates the active legs.
// Optional watchdog: define WATCHDOG_EN to fall back to standby when no
// command arrives for WDT_CYCLES cycles while driving.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   cmd_valid  - command valid
//   cmd        - direction (0=STANDBY, 1=FORWARD, 2=RIGHT, 3=LEFT)
//   cmd_ready  - command accepted when cmd_valid && cmd_ready
//   duty       - PWM duty, sampled every cycle
//   motors     - registered legs {A_d, A_i, B_d, B_i}
//   dir_out    - direction currently applied
//   busy       - high during dead time or minimum hold
//   wdt_trip   - watchdog fired, sticky until the next accepted command
module motor_dir_sequencer
    import microbot_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned MIN_HOLD    = 8,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned WDT_CYCLES  = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd,
    output logic                cmd_ready,
    input  logic [PWM_BITS-1:0] duty,
    output logic [3:0]          motors,
    output logic [1:0]          dir_out,
    output logic                busy,
    output logic                wdt_trip
);

    localparam int unsigned CNT_MAX = (DEAD_CYCLES > MIN_HOLD) ? DEAD_CYCLES : MIN_HOLD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 1);

    seq_state_t       state, state_n;
    dir_t             dir_q, dir_n, pend_q, pend_n;
    dir_t             cmd_dir;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       motors_n;
    logic             ready_n, busy_n;
    logic             accept;
    logic             gate;
    logic             wdt_fire;

    assign cmd_dir = dir_t'(cmd);
    assign accept  = cmd_valid & cmd_ready;
    assign dir_out = dir_q;

    motor_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty),
        .gate  (gate)
    );

`ifdef WATCHDOG_EN
    localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt, wdt_cnt_n;
    logic             trip_q, trip_n;

    assign wdt_fire = (state == RUN) && (wdt_cnt == WDT_LAST);
    assign wdt_trip = trip_q;

    // Watchdog: any accepted command is a kick; only counts while driving.
    always_comb begin
        wdt_cnt_n = wdt_cnt;
        trip_n    = trip_q;
        if (accept) begin
            wdt_cnt_n = '0;
            trip_n    = 1'b0;
        end else if (state == HOLD || state == RUN) begin
            if (wdt_fire) begin
                wdt_cnt_n = '0;
                trip_n    = 1'b1;
            end else if (wdt_cnt != WDT_LAST) begin
                wdt_cnt_n = wdt_cnt + WDT_W'(1);
            end
        end else begin
            wdt_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
            trip_q  <= 1'b0;
        end else begin
            wdt_cnt <= wdt_cnt_n;
            trip_q  <= trip_n;
        end
    end
`else
    assign wdt_fire = 1'b0;
    // WDT_CYCLES only shapes the watchdog; referenced here so every build
    // shares one parameter list.
    assign wdt_trip = 1'b0 & (WDT_CYCLES != 0);
`endif

    // Next state, counters and registered-output values.
    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        pend_n  = pend_q;
        cnt_n   = cnt;
        case (state)
            STBY: begin
                // Bridge is already off, so no dead time is needed here.
                if (accept && cmd_dir != STANDBY) begin
                    state_n = HOLD;
                    dir_n   = cmd_dir;
                    cnt_n   = HOLD_LOAD;
                end
            end
            DEAD: begin
                if (cnt == '0) begin
                    dir_n = pend_q;
                    if (pend_q == STANDBY) begin
                        state_n = STBY;
                    end else begin
                        state_n = HOLD;
                        cnt_n   = HOLD_LOAD;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RUN: begin
                if (accept) begin
                    if (cmd_dir != dir_q) begin
                        state_n = DEAD;
                        pend_n  = cmd_dir;
                        cnt_n   = DEAD_LOAD;
                    end
                end else if (wdt_fire) begin
                    state_n = DEAD;
                    pend_n  = STANDBY;
                    cnt_n   = DEAD_LOAD;
                end
            end
            default: begin
                state_n = STBY;
            end
        endcase

        // Legs follow the applied state one cycle later, so a change-over
        // always passes through at least one all-off cycle.
        motors_n = '0;
        if (state == HOLD || state == RUN) begin
            motors_n = dir_pattern(dir_q) & {4{gate}};
        end
        ready_n = (state_n == STBY) || (state_n == RUN);
        busy_n  = (state_n == DEAD) || (state_n == HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STBY;
            dir_q     <= STANDBY;
            pend_q    <= STANDBY;
            cnt       <= '0;
            motors    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            dir_q     <= dir_n;
            pend_q    <= pend_n;
            cnt       <= cnt_n;
            motors    <= motors_n;
            cmd_ready <= ready_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Bench for motor_dir_sequencer: directed commands push cycle-stamped
// expectations into a queue; a negedge monitor pops and compares them.
// Define WATCHDOG_EN to exercise the watchdog build.
module tb_motor_dir_sequencer;
    import microbot_pkg::*;

`ifdef WATCHDOG_EN
    localparam int TB_WDT = 1200;
`else
    localparam int TB_WDT = 50;
`endif

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic [7:0] duty;
    logic [3:0] motors;
    logic [1:0] dir_out;
    logic       busy;
    logic       wdt_trip;

    motor_dir_sequencer #(
        .DEAD_CYCLES (4),
        .MIN_HOLD    (8),
        .PWM_BITS    (8),
        .WDT_CYCLES  (TB_WDT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .duty      (duty),
        .motors    (motors),
        .dir_out   (dir_out),
        .busy      (busy),
        .wdt_trip  (wdt_trip)
    );

    typedef struct {
        int         cyc;
        logic [8:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   viol  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp_v);
        end
    endtask

    // Expected {motors, dir_out, busy, cmd_ready, wdt_trip} dt cycles from now.
    task automatic push(input int dt, input string nm, input logic [3:0] m,
                        input logic [1:0] d, input logic b, input logic r, input logic t);
        exp_t e;
        int   i;
        e.cyc  = cyc + dt;
        e.val  = {m, d, b, r, t};
        e.name = nm;
        i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] d);
        cmd_valid = 1'b1;
        cmd       = d;
    endtask

    // Monitor: compare due expectations; flag any shoot-through pattern.
    always @(negedge clk) begin
        logic [8:0] obs;
        exp_t       e;
        obs = {motors, dir_out, busy, cmd_ready, wdt_trip};
        if ((motors[3] & motors[2]) | (motors[1] & motors[0])) viol++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) check({e.name, "_late"}, cyc, e.cyc);
            else check(e.name, int'(obs), int'(e.val));
        end
    end

    task automatic pwm_window(input logic [7:0] d, input int exp_on, input string nm);
        int on_cnt;
        int other;
        duty = d;
        step(3);
        on_cnt = 0;
        other  = 0;
        repeat (256) begin
            @(negedge clk);
            if (motors == PAT_FORWARD) on_cnt++;
            else if (motors != 4'b0000) other++;
        end
        check(nm, on_cnt, exp_on);
        check({nm, "_other"}, other, 0);
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        duty      = 8'hFF;
        push(1, "reset_state", 4'b0000, STANDBY, 1'b0, 1'b1, 1'b0);
        step(3);
        rst_n = 1'b1;
        step(1);

        // Accepted STANDBY while idle changes nothing.
        drive(STANDBY);
        push(1, "stby_standby_noop", 4'b0000, STANDBY, 1'b0, 1'b1, 1'b0);
        step(1);
        cmd_valid = 1'b0;
        step(2);

        // FORWARD from standby: pattern 2 cycles after accept, 8 busy cycles.
        drive(FORWARD);
        push(1, "fwd_accept",     4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(2, "fwd_pattern",    4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(8, "fwd_hold_last",  4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(9, "fwd_run",        4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
        step(1);
        cmd_valid = 1'b0;
        step(11);

        // RIGHT from RUN/FORWARD: exactly 4 all-off cycles.
        drive(RIGHT);
        push(1,  "right_accept",  4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(2,  "right_dead0",   4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(3,  "right_dead1",   4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(4,  "right_dead2",   4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(5,  "right_dead3",   4'b0000, RIGHT,   1'b1, 1'b0, 1'b0);
        push(6,  "right_pattern", 4'b1001, RIGHT,   1'b1, 1'b0, 1'b0);
        push(13, "right_run",     4'b1001, RIGHT,   1'b0, 1'b1, 1'b0);
        step(1);
        cmd_valid = 1'b0;
        step(13);

        // LEFT held during HOLD is accepted only on the first RUN cycle.
        drive(FORWARD);
        push(1,  "fwd2_accept",   4'b1001, RIGHT,   1'b1, 1'b0, 1'b0);
        push(5,  "fwd2_dead_end", 4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(6,  "fwd2_pattern",  4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(12, "left_held_off", 4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(13, "fwd2_run",      4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
        push(14, "left_accept",   4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(15, "left_dead0",    4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(17, "left_dead2",    4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(18, "left_dead3",    4'b0000, LEFT,    1'b1, 1'b0, 1'b0);
        push(19, "left_pattern",  4'b0110, LEFT,    1'b1, 1'b0, 1'b0);
        push(26, "left_run",      4'b0110, LEFT,    1'b0, 1'b1, 1'b0);
        step(1);
        cmd_valid = 1'b0;
        step(5);
        drive(LEFT);
        step(8);
        cmd_valid = 1'b0;
        step(14);

        // Back to FORWARD, then PWM duty windows.
        drive(FORWARD);
        push(1,  "fwd3_accept",   4'b0110, LEFT,    1'b1, 1'b0, 1'b0);
        push(2,  "fwd3_dead0",    4'b0000, LEFT,    1'b1, 1'b0, 1'b0);
        push(6,  "fwd3_pattern",  4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(13, "fwd3_run",      4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
        step(1);
        cmd_valid = 1'b0;
        step(14);
        pwm_window(8'h40, 64,  "pwm_duty_40");
        pwm_window(8'h00, 0,   "pwm_duty_00");
        pwm_window(8'hFF, 256, "pwm_duty_ff");

        // Reset in the middle of a dead time.
        drive(RIGHT);
        push(1, "rst_pre_accept", 4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(2, "rst_pre_dead",   4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        step(1);
        cmd_valid = 1'b0;
        step(2);
        #1 rst_n = 1'b0;
        #1 check("async_reset", int'({motors, dir_out, busy, cmd_ready, wdt_trip}), int'(9'b0000_00_0_1_0));
        step(2);
        rst_n = 1'b1;
        push(1, "stby_after_reset", 4'b0000, STANDBY, 1'b0, 1'b1, 1'b0);
        step(1);
        drive(FORWARD);
        push(1, "post_rst_accept",  4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(2, "post_rst_pattern", 4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
        push(9, "post_rst_run",     4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
        step(1);
        cmd_valid = 1'b0;
        step(11);

        // Same-direction kick, then idle past the watchdog timeout.
        drive(FORWARD);
        push(1,      "same_dir_noop", 4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
        push(TB_WDT, "wdt_pre",       4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
`ifdef WATCHDOG_EN
        push(TB_WDT + 1, "wdt_fire",     4'b1010, FORWARD, 1'b1, 1'b0, 1'b1);
        push(TB_WDT + 2, "wdt_dead",     4'b0000, FORWARD, 1'b1, 1'b0, 1'b1);
        push(TB_WDT + 5, "wdt_standby",  4'b0000, STANDBY, 1'b0, 1'b1, 1'b1);
`else
        push(TB_WDT + 2, "no_wdt_run",   4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
        push(TB_WDT + 5, "no_wdt_run2",  4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
`endif
        step(1);
        cmd_valid = 1'b0;
        step(TB_WDT + 7);
        drive(FORWARD);
`ifdef WATCHDOG_EN
        push(1, "wdt_clear",         4'b0000, FORWARD, 1'b1, 1'b0, 1'b0);
        push(2, "wdt_clear_pattern", 4'b1010, FORWARD, 1'b1, 1'b0, 1'b0);
`else
        push(1, "late_noop",         4'b1010, FORWARD, 1'b0, 1'b1, 1'b0);
`endif
        step(1);
        cmd_valid = 1'b0;

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drain", q.size(), 0);
        check("no_shoot_through", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
